// File: rtl/mult_lut_pkg.sv
// Shared types and constants for the LUT multiplier and its burst MAC stage.
package mult_lut_pkg;

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    localparam int PROD_W = 4;
    localparam int OPND_W = 2;

    // Counter width able to hold 0..count-1, never narrower than one bit.
    function automatic int cnt_w(input int count);
        int w;
        w = $clog2(count);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mult_lut_mac_if.sv
// Operand input and burst result handshakes of the MAC stage.
interface mult_lut_mac_if
    import mult_lut_pkg::*;
#(
    parameter int ACC_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic              clear;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output in_valid, a, b, clear, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, a, b, clear, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/mult_lut_2x2.sv
// Combinational 2x2 -> 4 bit multiplier written as a lookup table.
module mult_lut_2x2
    import mult_lut_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    // Only the nine pairs with both operands non-zero give a non-zero product.
    always_comb begin
        p = '0;
        case ({a, b})
            4'b01_01: p = 4'd1;
            4'b01_10: p = 4'd2;
            4'b01_11: p = 4'd3;
            4'b10_01: p = 4'd2;
            4'b10_10: p = 4'd4;
            4'b10_11: p = 4'd6;
            4'b11_01: p = 4'd3;
            4'b11_10: p = 4'd6;
            4'b11_11: p = 4'd9;
            default:  p = 4'd0;
        endcase
    end

endmodule

// File: rtl/mult_lut_mac.sv
// Burst multiply-accumulate: sums COUNT LUT products and presents the result
// with a sticky overflow flag on a valid/ready output.
module mult_lut_mac
    import mult_lut_pkg::*;
#(
    parameter int ACC_W = 8,
    parameter int COUNT = 4
)(
    input  logic          clk,
    input  logic          rst_n,
    mult_lut_mac_if.slave bus
);

    localparam int CW = cnt_w(COUNT);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [PROD_W-1:0] prod, prod_q;
    logic              prod_v;
    logic [ACC_W-1:0]  acc;
    logic              ovf;
    logic              accept, last, out_hs;
    logic [ACC_W:0]    acc_sum;

    mult_lut_2x2 u_mul (.a(bus.a), .b(bus.b), .p(prod));

    assign accept  = bus.in_valid & bus.in_ready;
    assign last    = (cnt == CW'(COUNT - 1));
    assign out_hs  = (state == HOLD) & bus.out_ready;
    assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(prod_q);

    // Outputs decode only from state and registers; reset holds in_ready low.
    assign bus.in_ready  = rst_n & (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = (state == HOLD) ? acc : '0;
    assign bus.out_ovf   = (state == HOLD) & ovf;

    // State register; clear aborts exactly like reset.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) state <= ACCUM;
        else                     state <= state_nxt;
    end

    // Next state: last accept drains one cycle, then result is held until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && last) state_nxt = DRAIN;
            DRAIN:   state_nxt = HOLD;
            HOLD:    if (out_hs) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Datapath: product register, burst counter, accumulator with sticky carry.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            cnt    <= '0;
            prod_q <= '0;
            prod_v <= 1'b0;
            acc    <= '0;
            ovf    <= 1'b0;
        end else begin
            prod_v <= accept;
            if (accept) begin
                prod_q <= prod;
                cnt    <= last ? '0 : cnt + 1'b1;
            end
            // prod_v is never set in HOLD, so the two branches cannot collide.
            if (out_hs) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (prod_v) begin
                acc <= acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W]) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_lut_mac.sv
// Bench for mult_lut_mac: an 8-bit and a 4-bit accumulator instance share one
// stimulus stream and are checked against a burst-level reference model.
module tb_mult_lut_mac;

    localparam int COUNT   = 4;
    localparam int COLLECT = 0;
    localparam int WAITING = 1;
    localparam int SHOWING = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] a = '0;
    logic [1:0] b = '0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b1;
    bit         mon_en = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    // reference model: operands seen, running true sum, finished burst sum
    int ph = COLLECT;
    int n_in = 0;
    int part = 0;
    int res = 0;

    always #5 clk = ~clk;

    mult_lut_mac_if #(.ACC_W(8)) if8 ();
    mult_lut_mac_if #(.ACC_W(4)) if4 ();

    assign if8.in_valid  = in_valid;
    assign if8.a         = a;
    assign if8.b         = b;
    assign if8.clear     = clear;
    assign if8.out_ready = out_ready;
    assign if4.in_valid  = in_valid;
    assign if4.a         = a;
    assign if4.b         = b;
    assign if4.clear     = clear;
    assign if4.out_ready = out_ready;

    mult_lut_mac #(.ACC_W(8), .COUNT(COUNT)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    mult_lut_mac #(.ACC_W(4), .COUNT(COUNT)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Every cycle: compare both instances to the model, then advance the
    // model with the inputs that the coming rising edge will see.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rdy8", if8.in_ready, rst_n && ph == COLLECT);
            chk("rdy4", if4.in_ready, rst_n && ph == COLLECT);
            chk("vld8", if8.out_valid, ph == SHOWING);
            chk("vld4", if4.out_valid, ph == SHOWING);
            chk("sum8", if8.out_sum, (ph == SHOWING) ? res % 256 : 0);
            chk("ovf8", if8.out_ovf, (ph == SHOWING) && res >= 256);
            chk("sum4", if4.out_sum, (ph == SHOWING) ? res % 16 : 0);
            chk("ovf4", if4.out_ovf, (ph == SHOWING) && res >= 16);
            if (!rst_n || clear) begin
                ph = COLLECT; n_in = 0; part = 0;
            end else if (ph == COLLECT && in_valid) begin
                part += int'(a) * int'(b);
                n_in++;
                if (n_in == COUNT) begin
                    res = part; part = 0; n_in = 0; ph = WAITING;
                end
            end else if (ph == WAITING) begin
                ph = SHOWING;
            end else if (ph == SHOWING && out_ready) begin
                ph = COLLECT;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present one operand pair and hold it until the stage takes it.
    task automatic put(input int av, input int bv);
        int  t;
        bit  ok;
        t = 0;
        in_valid = 1'b1; a = 2'(av); b = 2'(bv);
        do begin
            @(negedge clk);
            ok = if8.in_ready;
            tick();
            t++;
        end while (!ok && t < 50);
        in_valid = 1'b0;
        if (!ok) chk("put_timeout", 0, 1);
    endtask

    task automatic put4(input int av, input int bv);
        repeat (COUNT) put(av, bv);
    endtask

    // Poll at falling edges until out_valid, with a bounded budget.
    task automatic wait_out();
        int t;
        t = 0;
        @(negedge clk);
        while (!if8.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("wait_out", if8.out_valid, 1);
    endtask

    initial begin
        // reset held with a live operand on the input
        in_valid = 1'b1; a = 2'd3; b = 2'd3;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_rdy", if8.in_ready, 0);
            chk("rst_vld", if8.out_valid, 0);
            chk("rst_sum", if8.out_sum, 0);
            chk("rst_ovf", if8.out_ovf, 0);
        end
        tick();
        rst_n = 1'b1; in_valid = 1'b0;

        // back-to-back (3,3)x4: 36, wraps to 4 with overflow on the 4-bit one
        out_ready = 1'b1;
        put4(3, 3);
        @(negedge clk);
        chk("drain_vld", if8.out_valid, 0);
        chk("drain_rdy", if8.in_ready, 0);
        @(negedge clk);
        chk("hold_rdy", if8.in_ready, 0);
        chk("b2b_vld", if8.out_valid, 1);
        chk("b2b_sum", if8.out_sum, 36);
        chk("b2b_ovf", if8.out_ovf, 0);
        chk("wrap_sum", if4.out_sum, 4);
        chk("wrap_ovf", if4.out_ovf, 1);
        @(negedge clk);
        chk("rdy_back", if8.in_ready, 1);
        tick();

        // gapped input: idle cycles contribute nothing
        put(0, 0); repeat ($urandom_range(0, 2)) tick();
        put(0, 2); repeat ($urandom_range(0, 2)) tick();
        put(2, 1); repeat ($urandom_range(0, 2)) tick();
        put(2, 2);
        wait_out();
        chk("gap_sum6", if8.out_sum, 6);
        tick();
        put(3, 0); repeat ($urandom_range(1, 3)) tick();
        put(3, 3); repeat ($urandom_range(1, 3)) tick();
        put(0, 1); put(1, 0);
        wait_out();
        chk("gap_sum9", if8.out_sum, 9);
        tick();

        // backpressure: result held, offered operands not consumed
        out_ready = 1'b0;
        put4(3, 3);
        wait_out();
        tick();
        in_valid = 1'b1; a = 2'd1; b = 2'd1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_sum", if8.out_sum, 36);
            chk("bp_rdy", if8.in_ready, 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        put4(1, 1);
        wait_out();
        chk("bp_next", if8.out_sum, 4);
        chk("nowrap_sum", if4.out_sum, 4);
        chk("nowrap_ovf", if4.out_ovf, 0);
        tick();

        // clear alongside the third accept drops the whole partial burst
        put(2, 2); put(2, 2);
        in_valid = 1'b1; a = 2'd2; b = 2'd2; clear = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b0;
        put4(1, 1);
        wait_out();
        chk("abort_sum", if8.out_sum, 4);
        tick();

        // reset during HOLD discards the held result
        out_ready = 1'b0;
        put4(3, 3);
        wait_out();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_hold_vld", if8.out_valid, 0);
        chk("rst_hold_sum", if8.out_sum, 0);
        tick();
        put4(2, 1);
        wait_out();
        chk("after_rst", if8.out_sum, 8);
        tick();

        // random traffic, backpressure, clears and resets; model checks all
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom % 3) != 0;
            a         = 2'($urandom);
            b         = 2'($urandom);
            out_ready = ($urandom % 4) != 0;
            clear     = ($urandom % 60) == 0;
            rst_n     = ($urandom % 97) != 0;
            tick();
        end
        in_valid = 1'b0; clear = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
